// File: rtl/mvau_stream_ctrl.sv
// Stream/replay controller ahead of the MVAU input buffer.
// Sequences synapse and neuron folds and drives buffer, weight address and compute strobes.
module mvau_stream_ctrl #(
    parameter int TI        = 1,
    parameter int MatrixW   = 20,
    parameter int MatrixH   = 20,
    parameter int SIMD      = 2,
    parameter int PE        = 2,
    parameter int BUF_ADDR  = ((MatrixW / SIMD) > 1) ? $clog2(MatrixW / SIMD) : 1,
    parameter int WMEM_ADDR = (((MatrixW / SIMD) * (MatrixH / PE)) > 1)
                              ? $clog2((MatrixW / SIMD) * (MatrixH / PE)) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_v,
    output logic                 in_rdy,
    input  logic                 out_rdy,
    output logic                 buf_wr_en,
    output logic                 buf_rd_en,
    output logic [BUF_ADDR-1:0]  buf_addr,
    output logic [WMEM_ADDR-1:0] wmem_addr,
    output logic                 do_mvau,
    output logic                 sf_clr,
    output logic                 sf_last
);

    localparam int SF  = MatrixW / SIMD;
    localparam int NF  = MatrixH / PE;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

    localparam logic [BUF_ADDR-1:0]  SF_MAX = BUF_ADDR'(SF - 1);
    localparam logic [NFW-1:0]       NF_MAX = NFW'(NF - 1);
    localparam logic [WMEM_ADDR-1:0] WM_MAX = WMEM_ADDR'(SF * NF - 1);

    if (TI < 1 || (MatrixW % SIMD) != 0 || (MatrixH % PE) != 0) begin : g_bad_cfg
        $error("mvau_stream_ctrl: illegal fold configuration");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [BUF_ADDR-1:0]  sf_cnt_q, sf_cnt_d;
    logic [NFW-1:0]       nf_cnt_q, nf_cnt_d;
    logic [WMEM_ADDR-1:0] wmem_q, wmem_d;
    logic                 beat;
    logic                 sf_wrap;
    logic                 nf_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sf_cnt_q <= '0;
            nf_cnt_q <= '0;
            wmem_q   <= '0;
        end else begin
            state_q  <= state_d;
            sf_cnt_q <= sf_cnt_d;
            nf_cnt_q <= nf_cnt_d;
            wmem_q   <= wmem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sf_cnt_d  = sf_cnt_q;
        nf_cnt_d  = nf_cnt_q;
        wmem_d    = wmem_q;
        beat      = 1'b0;
        in_rdy    = 1'b0;
        buf_wr_en = 1'b0;
        buf_rd_en = 1'b0;
        sf_wrap   = (sf_cnt_q == SF_MAX);
        nf_wrap   = (nf_cnt_q == NF_MAX);

        unique case (state_q)
            IDLE: begin
                if (in_v) state_d = WRITE;
            end
            WRITE: begin
                in_rdy    = out_rdy;
                beat      = in_v & out_rdy;
                buf_wr_en = beat;
                if (beat && sf_wrap && NF > 1) state_d = READ;
            end
            READ: begin
                buf_rd_en = 1'b1;
                beat      = out_rdy;
                if (beat && sf_wrap && nf_wrap) state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase

        // Weight address wraps with the last beat of the vector, so each vector starts at 0.
        if (beat) begin
            sf_cnt_d = sf_wrap ? '0 : sf_cnt_q + 1'b1;
            wmem_d   = (wmem_q == WM_MAX) ? '0 : wmem_q + 1'b1;
            if (sf_wrap) nf_cnt_d = nf_wrap ? '0 : nf_cnt_q + 1'b1;
        end

        do_mvau = beat;
        sf_clr  = beat & (sf_cnt_q == '0);
        sf_last = beat & sf_wrap;
    end

    assign buf_addr  = sf_cnt_q;
    assign wmem_addr = wmem_q;

endmodule
